// File: rtl/md_sched.sv
// md_sched: execute-stage multiply/divide sequencer with the HI/LO register pair.
// Accepts one operation per start pulse, holds busy for a fixed latency, then
// commits HI/LO atomically and pulses done.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start, op[2:0]     request and opcode (1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo)
//   a[31:0], b[31:0]   operands rs / rt
//   int_req            flushes a request presented in the same cycle
//   busy, done         in-flight flag, one-cycle completion pulse
//   hi[31:0], lo[31:0] committed HI/LO values
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        int_req,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 32;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [DW-1:0] pend_hi, pend_hi_n, pend_lo, pend_lo_n;
  logic          pend_ok, pend_ok_n;
  logic [DW-1:0] hi_n, lo_n;
  logic          done_n;

  // Datapath: 64-bit products and a magnitude-based divider
  logic [2*DW-1:0] prod_s, prod_u;
  logic            a_neg, b_neg;
  logic [DW-1:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;

  always_comb begin
    prod_s = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
    prod_u = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    a_neg  = (op == OP_DIV) && a[DW-1];
    b_neg  = (op == OP_DIV) && b[DW-1];
    a_mag  = a_neg ? DW'(~a + 32'd1) : a;
    // Zero divisor is replaced by 1 so the divider never sees it; the result is dropped anyway.
    if (b == '0)
      b_mag = DW'(1);
    else
      b_mag = b_neg ? DW'(~b + 32'd1) : b;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000, sign positive.
    quot  = (a_neg ^ b_neg) ? DW'(~q_mag + 32'd1) : q_mag;
    rem   = a_neg ? DW'(~r_mag + 32'd1) : r_mag;
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    count_n   = count;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_ok_n = pend_ok;
    hi_n      = hi;
    lo_n      = lo;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !int_req) begin
          case (op)
            OP_MULT: begin
              state_n   = MUL;
              count_n   = CW'(MULT_CYCLES);
              pend_hi_n = prod_s[2*DW-1:DW];
              pend_lo_n = prod_s[DW-1:0];
              pend_ok_n = 1'b1;
            end
            OP_MULTU: begin
              state_n   = MUL;
              count_n   = CW'(MULT_CYCLES);
              pend_hi_n = prod_u[2*DW-1:DW];
              pend_lo_n = prod_u[DW-1:0];
              pend_ok_n = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_n   = DIV;
              count_n   = CW'(DIV_CYCLES);
              pend_hi_n = rem;
              pend_lo_n = quot;
              pend_ok_n = (b != '0);
            end
            OP_MTHI: hi_n = a;
            OP_MTLO: lo_n = a;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        // In flight: start and int_req are ignored until the commit edge.
        if (count == CW'(1)) begin
          state_n = IDLE;
          count_n = '0;
          done_n  = 1'b1;
          if (pend_ok) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
        end else begin
          count_n = count - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_ok <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_ok <= pend_ok_n;
      hi      <= hi_n;
      lo      <= lo_n;
      busy    <= (state_n != IDLE);
      done    <= done_n;
    end
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Controller for the execute-stage multiply/divide resource and its HI/LO register pair.
- Accepts one operation per start pulse from stage_execute and sequences it over a fixed multi-cycle latency.
- Drives busy so decode stalls dependent instructions, and commits HI/LO atomically at the end of the operation.
- Honours int_req so that an operation in a flushed execute slot never starts.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu; legal range 1..255.
DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..255.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  operation request from the execute stage, sampled on each rising edge.
op  input  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no effect).
a  input  32  operand rs: dividend or multiplicand; data source for mthi/mtlo.
b  input  32  operand rt: divisor or multiplier.
int_req  input  1  CP0 interrupt/exception request; flushes the request in the current cycle.
busy  output  1  high while a mult/div is in flight.
done  output  1  one-cycle pulse in the cycle after HI/LO commit.
hi  output  32  committed HI value.
lo  output  32  committed LO value.

Behaviour:
- Reset (reset=1 at posedge):
  - state=IDLE, counter=0.
  - hi=0, lo=0, busy=0, done=0.
  - Pending result registers cleared.
  - Reset takes priority over everything, including an operation in flight; that operation is discarded with no commit.
- Acceptance: a request is accepted at a posedge when start=1, int_req=0 and state=IDLE.
  - start with int_req=1 is ignored entirely, including mthi/mtlo.
  - start while busy=1 is a protocol violation; it is ignored and does not change state, the counter or the pending registers.
- mthi/mtlo:
  - Written at the accepting edge: hi<=a or lo<=a.
  - busy stays 0 and done is not pulsed.
  - The new value is visible on hi/lo in the next cycle.
- Result computation:
  - mult/multu compute the 64-bit product at the accepting edge into pending registers, using operand values sampled at that edge.
  - Signed product for mult, unsigned for multu.
  - pend_hi = product[63:32], pend_lo = product[31:0].
- div/divu:
  - pend_lo = quotient truncated toward zero; pend_hi = remainder, sign following the dividend (div).
  - divu is fully unsigned.
  - div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divisor 0: the operation is still sequenced (busy for DIV_CYCLES) but no commit is made; hi/lo are unchanged and done still pulses.
- State machine IDLE/MUL/DIV:
  - IDLE -> MUL on accepted mult/multu, counter<=MULT_CYCLES.
  - IDLE -> DIV on accepted div/divu, counter<=DIV_CYCLES.
  - In MUL/DIV the counter decrements each edge.
  - At the edge where counter==1: commit hi/lo from the pending registers, state<=IDLE, done<=1 for exactly one cycle.
- busy timing:
  - busy = (state!=IDLE), registered.
  - busy rises in the cycle after the accepting edge and stays high for exactly N cycles (N=MULT_CYCLES or DIV_CYCLES).
  - busy falls in the same cycle in which the new hi/lo appear.
- Back-to-back operation: a new start may be accepted at the first edge where busy=0, i.e. the cycle in which done=1.
- int_req during MUL/DIV has no effect; the in-flight operation belongs to an already-committed instruction and completes normally.
- hi/lo change only on reset, on an accepted mthi/mtlo, or at a commit edge; they are never partially updated.
- Operands are not re-sampled after acceptance; a and b may change freely while busy.

Test Plan:
- Reset, then start op=1 (mult), a=0xFFFFFFFE (-2), b=3 -> busy high for exactly 5 cycles; on fall hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- op=2 (multu), a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- op=3 (div), a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Follow with div by b=0 -> busy 10 cycles, hi/lo unchanged, done pulses.
- start op=1 with int_req=1 -> busy stays 0, hi/lo unchanged. start op=5 (mthi), a=0x1234 with int_req=0 -> hi=0x1234 next cycle, busy stays 0.
- Accept div, assert int_req mid-operation and also raise start (op=6) while busy -> div completes at cycle 10 with the correct result; lo is not overwritten by the ignored mtlo.
- Accept mult, assert reset at busy cycle 3 -> next cycle busy=0, hi=lo=0, done never pulses. A new mult started immediately afterwards completes with the correct result.
